// File: rtl/axis_lbus_seg_packer.sv
// Multi-segment AXI-Stream to LBUS TX converter with packet tracking and a 2-entry skid output.
// Optional LBUS_KEEP_CHECK_EN adds keep-pattern checking that flags bad packets on their eop segment.
module axis_lbus_seg_packer #(
  parameter int NSEG      = 4,
  parameter int SEG_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NSEG*128-1:0]       s_axis_tdata,
  input  logic [NSEG*SEG_BYTES-1:0] s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [NSEG*128-1:0]       lbus_data,
  output logic [NSEG-1:0]           lbus_ena,
  output logic [NSEG-1:0]           lbus_sop,
  output logic [NSEG-1:0]           lbus_eop,
  output logic [NSEG-1:0]           lbus_err,
  output logic [NSEG*4-1:0]         lbus_mty,
  input  logic                      lbus_rdy
);

  typedef struct packed {
    logic [NSEG*128-1:0] data;
    logic [NSEG-1:0]     ena;
    logic [NSEG-1:0]     sop;
    logic [NSEG-1:0]     eop;
    logic [NSEG-1:0]     err;
    logic [NSEG*4-1:0]   mty;
  } beat_t;

  logic [NSEG-1:0]   cv_ena, cv_sop, cv_eop, cv_err_base, cv_err;
  logic [NSEG*4-1:0] cv_mty;
  logic              any_en, produce, accept, push;
  beat_t             cv_beat;

  beat_t out_q, out_d, skid_q, skid_d;
  logic  skid_v_q, skid_v_d;
  logic  tready_q, tready_d;
  logic  in_pkt_q, in_pkt_d;

  assign any_en  = |s_axis_tkeep;
  assign produce = any_en | s_axis_tlast;
  assign accept  = s_axis_tvalid & tready_q;
  assign push    = accept & produce;

  always_comb begin : convert
    logic found;
    cv_ena      = '0;
    cv_mty      = '0;
    cv_sop      = '0;
    cv_eop      = '0;
    cv_err_base = '0;
    for (int s = 0; s < NSEG; s++) begin
      cv_ena[s] = |s_axis_tkeep[SEG_BYTES*s +: SEG_BYTES];
      // Scanning downward leaves the lowest set keep bit as the empty count.
      for (int b = SEG_BYTES-1; b >= 0; b--) begin
        if (s_axis_tkeep[SEG_BYTES*s + b]) cv_mty[4*s +: 4] = 4'(b);
      end
    end
    found = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      if (cv_ena[s] && !found) begin
        cv_sop[s] = ~in_pkt_q;
        found     = 1'b1;
      end
    end
    found = 1'b0;
    for (int s = NSEG-1; s >= 0; s--) begin
      if (cv_ena[s] && !found) begin
        cv_eop[s] = s_axis_tlast;
        found     = 1'b1;
      end
    end
    if (!any_en && s_axis_tlast) begin
      cv_ena[0]      = 1'b1;
      cv_sop[0]      = ~in_pkt_q;
      cv_eop[0]      = 1'b1;
      cv_mty[3:0]    = 4'hF;
      cv_err_base[0] = 1'b1;
    end
  end

`ifdef LBUS_KEEP_CHECK_EN
  logic viol;
  logic bad_pkt_q, bad_pkt_d;

  always_comb begin : keep_check
    logic below, above;
    viol  = 1'b0;
    below = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      above = 1'b0;
      for (int t = s + 1; t < NSEG; t++) above = above | cv_ena[t];
      if (cv_ena[s]) begin
        if (s_axis_tkeep[SEG_BYTES*s +: SEG_BYTES] != (16'hFFFF << cv_mty[4*s +: 4])) viol = 1'b1;
        if ((cv_mty[4*s +: 4] != 4'd0) && !cv_eop[s]) viol = 1'b1;
      end else begin
        // Holes are never legal; leading gaps only on the sop beat, trailing only on tlast.
        if (below && above) viol = 1'b1;
        if (above && !below && in_pkt_q) viol = 1'b1;
        if (below && !above && !s_axis_tlast) viol = 1'b1;
      end
      below = below | cv_ena[s];
    end
    if (!any_en) viol = 1'b0;
  end

  always_comb begin
    bad_pkt_d = bad_pkt_q;
    if (push) bad_pkt_d = s_axis_tlast ? 1'b0 : (bad_pkt_q | viol);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bad_pkt_q <= 1'b0;
    else        bad_pkt_q <= bad_pkt_d;
  end

  assign cv_err = cv_err_base | (cv_eop & {NSEG{bad_pkt_q | viol}});
`else
  assign cv_err = cv_err_base;
`endif

  assign cv_beat = '{data: s_axis_tdata, ena: cv_ena, sop: cv_sop, eop: cv_eop,
                     err: cv_err, mty: cv_mty};

  always_comb begin
    in_pkt_d = in_pkt_q;
    if (push) begin
      if (s_axis_tlast)         in_pkt_d = 1'b0;
      else if (!in_pkt_q)       in_pkt_d = 1'b1;
    end
  end

  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (!(|out_q.ena) || lbus_rdy) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        skid_v_d = push;
        if (push) skid_d = cv_beat;
      end else if (push) begin
        out_d = cv_beat;
      end else begin
        out_d.ena = '0;
      end
    end else if (push) begin
      skid_d   = cv_beat;
      skid_v_d = 1'b1;
    end
    tready_d = ~skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      tready_q <= 1'b0;
      in_pkt_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      tready_q <= tready_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign lbus_data     = out_q.data;
  assign lbus_ena      = out_q.ena;
  assign lbus_sop      = out_q.sop;
  assign lbus_eop      = out_q.eop;
  assign lbus_err      = out_q.err;
  assign lbus_mty      = out_q.mty;

endmodule

// File: tb/tb_axis_lbus_seg_packer.sv
// Directed self-checking bench for axis_lbus_seg_packer (NSEG=4) with an in-order expected-beat queue.
module tb_axis_lbus_seg_packer;

  localparam logic [63:0] K_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [511:0] lbus_data;
  logic [3:0]   lbus_ena, lbus_sop, lbus_eop, lbus_err;
  logic [15:0]  lbus_mty;
  logic         lbus_rdy;

  typedef struct {
    logic [3:0]   ena, sop, eop, err;
    logic [15:0]  mty;
    logic [511:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic rdy_toggle = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  int   rdy_ph = 0;

  axis_lbus_seg_packer #(.NSEG(4), .SEG_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .lbus_data(lbus_data), .lbus_ena(lbus_ena), .lbus_sop(lbus_sop), .lbus_eop(lbus_eop),
    .lbus_err(lbus_err), .lbus_mty(lbus_mty), .lbus_rdy(lbus_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] mkdata(input int id);
    logic [511:0] d;
    for (int s = 0; s < 4; s++) d[128*s +: 128] = {id[31:0], 32'(s), 64'hA5A5_5A5A_C3C3_3C3C};
    return d;
  endfunction

  task automatic push_exp(input logic [3:0] ena, input logic [3:0] sop, input logic [3:0] eop,
                          input logic [15:0] mty, input logic [3:0] err, input int id);
    exp_t e;
    e.ena = ena; e.sop = sop; e.eop = eop; e.mty = mty; e.err = err; e.data = mkdata(id);
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [63:0] keep, input logic last, input int id);
    logic ready_now;
    int   n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tdata  = mkdata(id);
    do begin
      ready_now = s_axis_tready;
      @(posedge clk); #1;
      n++;
    end while (!ready_now && n < 50);
    check("accept", 512'(ready_now), 512'(1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 512'(exp_q.size()), 512'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && (|lbus_ena) && lbus_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 512'(lbus_ena), 512'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("ena",  512'(lbus_ena),  512'(mon_e.ena));
        check("sop",  512'(lbus_sop),  512'(mon_e.sop));
        check("eop",  512'(lbus_eop),  512'(mon_e.eop));
        check("mty",  512'(lbus_mty),  512'(mon_e.mty));
        check("err",  512'(lbus_err),  512'(mon_e.err));
        check("data", lbus_data, mon_e.data);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle) begin
        lbus_rdy = rdy_pat[rdy_ph];
        rdy_ph   = (rdy_ph + 1) % 4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] bad_err;
`ifdef LBUS_KEEP_CHECK_EN
    bad_err = 4'b1000;
`else
    bad_err = 4'b0000;
`endif
    rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; lbus_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 512'(s_axis_tready), 512'(0));
    check("rst_ena", 512'(lbus_ena), 512'(0));
    check("rst_sop_eop", 512'({lbus_sop, lbus_eop, lbus_err}), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("tready_after_rst", 512'(s_axis_tready), 512'(1));

    // Single full beat, latency 1 clk.
    push_exp(4'hF, 4'h1, 4'h8, 16'h0000, 4'h0, 1);
    send(K_ALL, 1'b1, 1);
    check("latency_ena", 512'(lbus_ena), 512'(4'hF));
    drain();

    // 3-beat packet, partial last beat.
    push_exp(4'hF, 4'h1, 4'h0, 16'h0000, 4'h0, 2);
    push_exp(4'hF, 4'h0, 4'h0, 16'h0000, 4'h0, 3);
    push_exp(4'h3, 4'h0, 4'h2, 16'h0030, 4'h0, 4);
    send(K_ALL, 1'b0, 2);
    send(K_ALL, 1'b0, 3);
    send(64'h0000_0000_FFF8_FFFF, 1'b1, 4);
    drain();

    // Empty non-last beat mid-packet is dropped.
    push_exp(4'hF, 4'h1, 4'h0, 16'h0000, 4'h0, 5);
    push_exp(4'h1, 4'h0, 4'h1, 16'h0000, 4'h0, 7);
    send(K_ALL, 1'b0, 5);
    send(64'h0, 1'b0, 6);
    send(64'h0000_0000_0000_FFFF, 1'b1, 7);
    drain();

    // Empty tlast beat inside a packet, then outside a packet.
    push_exp(4'hF, 4'h1, 4'h0, 16'h0000, 4'h0, 8);
    push_exp(4'h1, 4'h0, 4'h1, 16'h000F, 4'h1, 9);
    push_exp(4'h1, 4'h1, 4'h1, 16'h000F, 4'h1, 10);
    send(K_ALL, 1'b0, 8);
    send(64'h0, 1'b1, 9);
    send(64'h0, 1'b1, 10);
    drain();

    // Leading disabled segment on sop beat, partial eop seg; then single-segment packet.
    push_exp(4'hE, 4'h2, 4'h0, 16'h0000, 4'h0, 11);
    push_exp(4'h1, 4'h0, 4'h1, 16'h0006, 4'h0, 12);
    push_exp(4'h4, 4'h4, 4'h4, 16'h0000, 4'h0, 13);
    send(64'hFFFF_FFFF_FFFF_0000, 1'b0, 11);
    send(64'h0000_0000_0000_FFC0, 1'b1, 12);
    send(64'h0000_FFFF_0000_0000, 1'b1, 13);
    drain();

    // Non-contiguous keep in a middle beat; the following packet is clean.
    push_exp(4'hF, 4'h1, 4'h0, 16'h0000, 4'h0, 14);
    push_exp(4'hF, 4'h0, 4'h0, 16'h0000, 4'h0, 15);
    push_exp(4'hF, 4'h0, 4'h8, 16'h0000, bad_err, 16);
    push_exp(4'hF, 4'h1, 4'h8, 16'h0000, 4'h0, 17);
    send(K_ALL, 1'b0, 14);
    send(64'hFFFF_FF0F_FFFF_FFFF, 1'b0, 15);
    send(K_ALL, 1'b1, 16);
    send(K_ALL, 1'b1, 17);
    drain();

    // Skid: rdy drops with a beat held, next beat lands in skid and tready falls.
    push_exp(4'hF, 4'h1, 4'h8, 16'h0000, 4'h0, 30);
    push_exp(4'h3, 4'h1, 4'h2, 16'h00C0, 4'h0, 31);
    send(K_ALL, 1'b1, 30);
    lbus_rdy = 1'b0;
    send(64'h0000_0000_F000_FFFF, 1'b1, 31);
    check("tready_drop", 512'(s_axis_tready), 512'(0));
    @(posedge clk); #1;
    check("hold_data", lbus_data, mkdata(30));
    check("hold_ena", 512'(lbus_ena), 512'(4'hF));
    check("tready_held_low", 512'(s_axis_tready), 512'(0));
    lbus_rdy = 1'b1;
    drain();
    check("tready_recover", 512'(s_axis_tready), 512'(1));

    // Back-to-back packets with rdy toggling 1,0,0,1.
    rdy_toggle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        push_exp(4'hF, 4'h1, 4'h8, 16'h0000, 4'h0, 40 + i);
        send(K_ALL, 1'b1, 40 + i);
      end else begin
        push_exp(4'h3, 4'h1, 4'h2, 16'h00C0, 4'h0, 40 + i);
        send(64'h0000_0000_F000_FFFF, 1'b1, 40 + i);
      end
    end
    drain();
    rdy_toggle = 1'b0;
    lbus_rdy   = 1'b1;

    // Reset mid-packet: next beat starts a fresh packet.
    push_exp(4'hF, 4'h1, 4'h0, 16'h0000, 4'h0, 60);
    send(K_ALL, 1'b0, 60);
    drain();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_tready", 512'(s_axis_tready), 512'(0));
    check("midrst_ena", 512'(lbus_ena), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(4'hF, 4'h1, 4'h8, 16'h0000, 4'h0, 61);
    send(K_ALL, 1'b1, 61);
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("idle_ena", 512'(lbus_ena), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_lbus_seg_packer.md
Name: axis_lbus_seg_packer

Overview:
- Converts a multi-segment AXI-Stream beat into the segmented LBUS transmit format (per-segment ena/sop/eop/mty/err) for the 100G MAC TX path.
- Parametrised successor of the single-segment keep-to-mty converter, generalised to NSEG 128-bit segments.
- Adds packet-state tracking and a registered, fully back-pressured 2-entry skid output stage.
- Sits between the user AXIS TX FIFO and the MAC LBUS TX port.

Parameters:
- NSEG, 4, number of 128-bit LBUS segments per beat (1..8)
- SEG_BYTES, 16, bytes per segment; fixed at 16, mty width = 4

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  NSEG*128  input data; segment s = bits [128s+127:128s]
- s_axis_tkeep  in  NSEG*16  byte keep; segment s = bits [16s+15:16s]
- s_axis_tlast  in  1  last beat of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- lbus_data  out  NSEG*128  segment data, passed through unmodified
- lbus_ena  out  NSEG  segment enable
- lbus_sop  out  NSEG  start of packet
- lbus_eop  out  NSEG  end of packet
- lbus_err  out  NSEG  error flag
- lbus_mty  out  NSEG*4  empty byte count per segment
- lbus_rdy  in  1  MAC ready; an output beat transfers when any lbus_ena bit=1 and lbus_rdy=1

Behaviour:
- Reset, asynchronous on rst_n low: all lbus_* outputs = 0; s_axis_tready = 0 while rst_n is low, then 1 from the first clk after release; skid buffer empty; in_pkt = 0.
- Per-segment conversion, combinational, ahead of the register:
  - seg_en[s] = OR of keep slice s.
  - mty[s] = index of the lowest set keep bit in slice s; a slice of all ones gives mty = 0.
  - A slice with no keep bits gives ena = 0 and mty = 0.
- sop: asserted on the lowest enabled segment of the first non-empty beat while in_pkt = 0.
- eop: asserted on the highest enabled segment of a tlast beat.
- sop and eop may both be set in one segment (single-segment packet).
- in_pkt: set on an accepted beat carrying sop without eop; cleared on an accepted tlast beat.
- Beat with all keep = 0 and tlast = 0: consumed and dropped; no output; in_pkt unchanged.
- Beat with all keep = 0 and tlast = 1:
  - Emitted as segment 0 with ena = 1, eop = 1, mty = 15, err = 1.
  - sop = 1 if in_pkt = 0.
  - in_pkt cleared.
- Latency: 1 clk from accepted input to lbus_* valid when the output is empty.
- Skid buffer (main register plus skid register):
  - s_axis_tready = NOT skid_full, registered.
  - Full throughput (1 beat/clk) while lbus_rdy = 1.
  - On lbus_rdy falling, one in-flight beat lands in the skid register and tready drops the next clk.
  - On lbus_rdy rising, skid contents drain first; ordering is always preserved.
- lbus_ena = 0 when no beat is held; lbus_data/mty/sop/eop/err then hold their last value, don't-care.
- Held outputs are stable while lbus_rdy = 0; no beat is ever duplicated or lost.
- lbus_err = 0 except as stated in this section and in Optional Feature.
- rst_n asserted mid-packet: packet discarded, in_pkt = 0; the next beat is treated as a new sop.

Optional Feature:
- Macro: LBUS_KEEP_CHECK_EN.
- Defined:
  - Each enabled segment's keep must be contiguous from bit 15 downward (ones from MSB down to mty).
  - Only the eop segment may have mty ≠ 0.
  - Only the sop beat's leading segments may be disabled.
  - Any violation sets lbus_err on the eop segment of that packet, sticky across the packet's beats until eop.
  - The flag is tracked in a registered bad_pkt bit, cleared at eop output and on reset.
- Not defined: no checking; lbus_err set only by the empty-tlast case; no bad_pkt register.

Test Plan:
- NSEG=4, one beat, tkeep=all ones, tlast=1 -> ena=4'b1111, sop=4'b0001, eop=4'b1000, mty all 0, output 1 clk after acceptance.
- 3-beat packet, last beat tkeep=16'hFFFF,16'hFFF8 in seg0/seg1, rest 0 -> beat1 sop[0]=1; beat3 ena=4'b0011, eop=4'b0010, mty[1]=3.
- Back-to-back packets with lbus_rdy toggling 1,0,0,1 every clk -> output beat sequence identical to input; tready low 1 clk after each rdy drop; no loss or duplication.
- Beat tkeep=0, tlast=0 mid-packet, then tlast beat -> empty beat absent at output; in_pkt holds; eop on the following beat.
- Beat tkeep=0, tlast=1 with in_pkt=1 -> seg0 ena=1, eop=1, mty=15, err=1, sop=0.
- LBUS_KEEP_CHECK_EN defined, middle beat seg2 tkeep=16'hFF0F -> err=1 on that packet's eop segment only; next packet err=0. Macro undefined: err=0.
